// File: rtl/music_pkg.sv
// Shared encodings for the music player: FSM states, volume limits, speed and order codes,
// and the song-number wrap helpers used by the playback sequencer.
package music_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PLAY  = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_PLAY  = PLAY,
        ST_PAUSE = PAUSE,
        ST_GAP   = GAP
    } state_t;

    localparam logic [2:0] VOL_MIN = 3'd1;
    localparam logic [2:0] VOL_MAX = 3'd5;

    localparam logic [1:0] SPD_X1   = 2'd0;
    localparam logic [1:0] SPD_X125 = 2'd1;
    localparam logic [1:0] SPD_X075 = 2'd2;

    localparam logic ORD_SEQ    = 1'b0;
    localparam logic ORD_SINGLE = 1'b1;

    // Songs are numbered 1..last; 0 means "no song" and steps into range.
    function automatic logic [1:0] song_inc(input logic [1:0] cur, input logic [1:0] last);
        return (cur >= last) ? 2'd1 : cur + 2'd1;
    endfunction

    function automatic logic [1:0] song_dec(input logic [1:0] cur, input logic [1:0] last);
        return (cur <= 2'd1) ? last : cur - 2'd1;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// Inter-song silence timer: load starts a GAP_CYCLES countdown, expire is high for the
// last cycle of the gap, clear abandons it.
module gap_timer #(
    parameter int unsigned GAP_CYCLES = 24'd5_000_000,
    parameter int          GAP_W      = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expire
);

    logic [GAP_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= GAP_W'(GAP_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - GAP_W'(1);
        end
    end

    // Counter reads 1 during the final silent cycle, so the caller leaves GAP on the next edge.
    assign expire = (cnt == GAP_W'(1));

endmodule

// File: rtl/play_sequencer.sv
// Playback controller: turns key pulses and song_done into the order/music/volume/speed/play
// registers. Define PLAY_SEQUENCER_SHUFFLE_EN to pick the next song pseudo-randomly at gap expiry.
module play_sequencer
    import music_pkg::*;
#(
    parameter int          NUM_SONGS  = 3,
    parameter int unsigned GAP_CYCLES = 24'd5_000_000,
    parameter int          GAP_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play_key,
    input  logic       stop_key,
    input  logic       next_key,
    input  logic       prev_key,
    input  logic       order_key,
    input  logic       speed_key,
    input  logic       vol_up,
    input  logic       vol_dn,
    input  logic       song_done,
    output logic       order_reg,
    output logic [1:0] music_reg,
    output logic [2:0] volume_reg,
    output logic [1:0] speed_reg,
    output logic       play_reg,
    output logic       song_start,
    output logic [1:0] state_o
);

    localparam logic [1:0] LAST = 2'(NUM_SONGS);

    state_t     state, state_nxt;
    logic       order_nxt, play_nxt, start_nxt;
    logic [1:0] music_nxt, speed_nxt, seq_pick;
    logic [2:0] volume_nxt;
    logic       gap_load, gap_clear, gap_expire;

`ifdef PLAY_SEQUENCER_SHUFFLE_EN
    logic [7:0] lfsr;
    logic [1:0] cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 8'hA5;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign cand     = 2'((lfsr % 8'(NUM_SONGS)) + 8'd1);
    assign seq_pick = (cand == music_reg) ? song_inc(music_reg, LAST) : cand;
`else
    assign seq_pick = song_inc(music_reg, LAST);
`endif

    always_comb begin
        state_nxt  = state;
        music_nxt  = music_reg;
        play_nxt   = play_reg;
        start_nxt  = 1'b0;
        order_nxt  = order_key ? ~order_reg : order_reg;
        speed_nxt  = speed_reg;
        volume_nxt = volume_reg;

        if (speed_key) begin
            case (speed_reg)
                SPD_X1:   speed_nxt = SPD_X125;
                SPD_X125: speed_nxt = SPD_X075;
                default:  speed_nxt = SPD_X1;
            endcase
        end

        if (vol_up && !vol_dn && volume_reg < VOL_MAX)
            volume_nxt = volume_reg + 3'd1;
        else if (vol_dn && !vol_up && volume_reg > VOL_MIN)
            volume_nxt = volume_reg - 3'd1;

        // Single prioritised event per cycle; next/prev are not events while idle.
        if (stop_key) begin
            state_nxt = ST_IDLE;
            music_nxt = 2'd0;
            play_nxt  = 1'b0;
        end else if (state != ST_IDLE && next_key) begin
            state_nxt = ST_PLAY;
            music_nxt = song_inc(music_reg, LAST);
            play_nxt  = 1'b1;
            start_nxt = 1'b1;
        end else if (state != ST_IDLE && prev_key) begin
            state_nxt = ST_PLAY;
            music_nxt = song_dec(music_reg, LAST);
            play_nxt  = 1'b1;
            start_nxt = 1'b1;
        end else if (play_key) begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_PLAY;
                    music_nxt = 2'd1;
                    play_nxt  = 1'b1;
                    start_nxt = 1'b1;
                end
                ST_PAUSE: begin
                    state_nxt = ST_PLAY;
                    play_nxt  = 1'b1;
                end
                default: begin
                    state_nxt = ST_PAUSE;
                    play_nxt  = 1'b0;
                end
            endcase
        end else if (song_done && state == ST_PLAY) begin
            state_nxt = ST_GAP;
            play_nxt  = 1'b0;
        end else if (state == ST_GAP && gap_expire) begin
            state_nxt = ST_PLAY;
            music_nxt = (order_reg == ORD_SEQ) ? seq_pick : music_reg;
            play_nxt  = 1'b1;
            start_nxt = 1'b1;
        end
    end

    // Any exit from GAP (expiry, keys, stop) drops the countdown so it cannot fire later.
    assign gap_load  = (state != ST_GAP) && (state_nxt == ST_GAP);
    assign gap_clear = (state_nxt != ST_GAP);

    gap_timer #(
        .GAP_CYCLES(GAP_CYCLES),
        .GAP_W     (GAP_W)
    ) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (gap_load),
        .clear (gap_clear),
        .expire(gap_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            order_reg  <= ORD_SEQ;
            music_reg  <= 2'd0;
            volume_reg <= VOL_MIN;
            speed_reg  <= SPD_X1;
            play_reg   <= 1'b0;
            song_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            order_reg  <= order_nxt;
            music_reg  <= music_nxt;
            volume_reg <= volume_nxt;
            speed_reg  <= speed_nxt;
            play_reg   <= play_nxt;
            song_start <= start_nxt;
        end
    end

    assign state_o = state;

endmodule
